// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared types and helpers for the switch/button conditioner.
//  Revision    : 1.0  initial release
// ============================================================================
package sw_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } sw_state_t;

    // Width of the stability counter; it only needs to reach STABLE_CYCLES-1.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_ch
//  Description : One conditioner channel: 2-flop synchronizer, debounce FSM,
//                stability counter and registered level/rise/fall/toggle.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int STABLE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic sw_in,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_toggle
);

    localparam int                 c_cnt_w    = cnt_width(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [1:0]         r_sync;
    logic               w_s;
    sw_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;
    logic               r_toggle;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], sw_in};
        end
    end

    assign w_s = r_sync[1];

    // A candidate level must be seen STABLE_CYCLES times in a row; any
    // contrary sample drops back to the stable state without output activity.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= STABLE_LOW;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LOW: begin
                    if (w_s) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= c_cnt_one;
                    end
                end
                WAIT_HIGH: begin
                    if (!w_s) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state  <= STABLE_HIGH;
                        r_cnt    <= '0;
                        r_level  <= 1'b1;
                        r_rise   <= 1'b1;
                        r_toggle <= ~r_toggle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_s) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= c_cnt_one;
                    end
                end
                WAIT_LOW: begin
                    if (w_s) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign sw_level  = r_level;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;
    assign sw_toggle = r_toggle;

endmodule
`default_nettype wire

// File: rtl/sw_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sw_conditioner
//  Description : N independent switch/button conditioning channels.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_conditioner
    import sw_pkg::*;
#(
    parameter int N             = 2,
`ifdef SIMULATION
    parameter int STABLE_CYCLES = 4
`else
    parameter int STABLE_CYCLES = 500_000
`endif
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] sw_level,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic [N-1:0] sw_toggle
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        sw_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .nrst      (nrst),
            .sw_in     (sw_in[i]),
            .sw_level  (sw_level[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .sw_toggle (sw_toggle[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/sw_conditioner.md
# sw_conditioner

Input-side companion to the board's LED/indicator logic. It takes the raw, asynchronous, bouncing slide-switch and push-button lines from the pins and turns each one into three clean single-clock-domain signals: a debounced level, one-cycle rise and fall pulses, and a press-toggled latch. It sits directly behind the top-level pins and feeds every control consumer in the video design, such as mode select and aux-clock select.

## Interface
Parameters:
- N, 2, number of independent input channels.
- STABLE_CYCLES, 500_000, consecutive identical synchronized samples required to accept a new level. This is 10 ms at 50 MHz. Benches set 4. Legal range is ≥ 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- nrst  in  1  asynchronous active-low reset.
- sw_in  in  N  raw pin inputs, asynchronous to clk.
- sw_level  out  N  debounced level.
- sw_rise  out  N  one-cycle pulse on an accepted 0→1 change.
- sw_fall  out  N  one-cycle pulse on an accepted 1→0 change.
- sw_toggle  out  N  inverts on every sw_rise.

## Operation
- Each channel is fully independent; there is no cross-channel interaction.
- Each bit of sw_in passes through a 2-flop synchronizer. The synchronized value is s.
- Per-channel FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
  - STABLE_LOW: if s=1, go to WAIT_HIGH and set cnt=1.
  - WAIT_HIGH:
    - If s=0, return to STABLE_LOW and set cnt=0. This is a bounce: no pulse, no level change.
    - Else if cnt=STABLE_CYCLES-1, go to STABLE_HIGH, set sw_level=1, pulse sw_rise, flip sw_toggle.
    - Otherwise increment cnt.
  - STABLE_HIGH and WAIT_LOW: the mirror image of the above, producing sw_fall and sw_level=0.
- The counter is $clog2(STABLE_CYCLES) bits wide. It never wraps, because the exit condition precedes overflow.
- Reset values:
  - Synchronizer flops: 0.
  - FSM: STABLE_LOW, cnt=0.
  - sw_level, sw_rise, sw_fall, sw_toggle: all 0.
- An input that is already high while nrst is asserted is treated as a fresh press after release. It produces sw_rise after the full latency.
- Reset asserted mid-count aborts the count immediately, asynchronously. No pulse is emitted, then or on release.
- All outputs are registered; none combinationally depends on sw_in.

## Timing
- sw_in changes to a new value before edge k and then holds it:
  - s shows the new value after edge k+1.
  - sw_level changes, and the pulse asserts, after edge k+1+STABLE_CYCLES.
  - With STABLE_CYCLES=4, that is the 5th edge after the change is first sampled.
- sw_rise and sw_fall are high for exactly one cycle per accepted transition. They are never high simultaneously on the same channel.
- A glitch on s shorter than STABLE_CYCLES cycles produces no output activity.
- A glitch of exactly STABLE_CYCLES cycles is accepted.
- The minimum spacing between two accepted transitions on one channel is STABLE_CYCLES cycles.
- sw_toggle changes in the same cycle that sw_rise is high.

## Structure
- Package sw_pkg holds:
  - the enum sw_state_t {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW};
  - a function computing counter width from STABLE_CYCLES.
- Sub-module sw_debounce_ch contains one channel: synchronizer, FSM, counter and the four output flops.
- sw_conditioner instantiates N copies of sw_debounce_ch in a generate loop and contains no other logic.
- The top level instantiates sw_conditioner with STABLE_CYCLES=500_000, or 4 under `SIMULATION`.

## Test plan
Every directed scenario uses STABLE_CYCLES=4 and N=2.
- **Clean press.** Reset, then raise sw_in[0] and hold it.
  - sw_level[0]=1 after the 5th edge.
  - sw_rise[0] is high for 1 cycle in that same cycle.
  - sw_toggle[0]=1.
  - Channel 1 outputs stay 0.
- **Bounce rejection.** Drive sw_in[0] with the pattern 1,1,1,0 repeated for 40 cycles (3-cycle highs).
  - sw_level, sw_rise and sw_toggle all stay 0.
- **Release after press.** Press as in the first scenario, then drop sw_in[0] and hold it.
  - sw_fall[0] pulses once, 5 edges after the drop.
  - sw_level[0]=0.
  - sw_toggle[0] remains 1.
- **Double press.** Two clean presses separated by a clean release.
  - sw_toggle[0] sequence is 0→1→1→0.
  - Exactly 2 sw_rise pulses and 1 sw_fall pulse.
- **Reset mid-count.**
  - Raise sw_in[1]. Assert nrst 2 cycles later for 3 cycles, keeping sw_in[1]=1.
  - All outputs read 0 immediately on assertion.
  - After release, sw_rise[1] pulses exactly once, 5 edges after the first post-reset edge.
- **Simultaneous channels.** Raise both inputs in the same cycle.
  - Both sw_rise bits pulse in the same cycle, 5 edges later.
